datapath_sequencer: RTL and testbench

- Hardwired control unit for the single-bus CPU datapath (R0–R15, HI, LO, Y, Z, PC, IR, MAR, MDR, sign-extended C).
- Steps a fetch/decode/execute state machine and drives every datapath in/out strobe, the ALU op code and the memory Read/Write handshake.
- Sits beside the datapath. It reads IR bits back from the datapath and drives all bus-source and bus-sink enables.

---
 rtl/datapath_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Hardwired fetch/decode/execute control unit for the single-bus CPU datapath.
// Optional memory-wait watchdog: define DATAPATH_SEQUENCER_MEM_TIMEOUT_EN to add the fault port.
module datapath_sequencer #(
    parameter int ALU_OP_W    = 5,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic                Csignextendedout,
    output logic                Read,
    output logic                Write,
    output logic [15:0]         Rin,
    output logic [15:0]         Rout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                illegal
`ifdef DATAPATH_SEQUENCER_MEM_TIMEOUT_EN
    ,
    output logic                fault
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_DEC,
        S_E1, S_E2, S_E3, S_E4, S_E5, S_HALTED
    } state_t;

    typedef enum logic [2:0] {
        C_LD, C_ST, C_ALU, C_IMM, C_MULDIV, C_NOP, C_HALT, C_ILL
    } op_class_t;

    localparam logic [4:0] OP_ADD = 5'b00011;

    if (ALU_OP_W < 5) begin : g_bad_alu_op_w
        $error("ALU_OP_W must be at least the opcode field width");
    end
    if (MEM_TIMEOUT < 2) begin : g_bad_mem_timeout
        $error("MEM_TIMEOUT must be at least 2");
    end

    function automatic op_class_t decode_class(input logic [4:0] op);
        op_class_t c;
        case (op)
            5'b00000:                     c = C_LD;
            5'b00001:                     c = C_ST;
            5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b00111, 5'b01000,
            5'b01001, 5'b01010:           c = C_ALU;
            5'b01011, 5'b01100, 5'b01101: c = C_IMM;
            5'b01110, 5'b01111:           c = C_MULDIV;
            5'b11010:                     c = C_NOP;
            5'b11011:                     c = C_HALT;
            default:                      c = C_ILL;
        endcase
        return c;
    endfunction

    state_t                r_state;
    state_t                w_next;
    op_class_t             w_class;
    logic [4:0]            w_op;
    logic [15:0]           w_ra_oh;
    logic [15:0]           w_rb_oh;
    logic [15:0]           w_rc_oh;
    logic [ALU_OP_W-1:0]   w_op_alu;
    logic [ALU_OP_W-1:0]   w_add_alu;
    logic                  w_in_wait;
    logic                  w_timeout;
    logic                  w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_class     = decode_class(w_op);
    assign w_ra_oh     = 16'h0001 << ir[26:23];
    assign w_rb_oh     = 16'h0001 << ir[22:19];
    assign w_rc_oh     = 16'h0001 << ir[18:15];
    assign w_op_alu    = ALU_OP_W'(w_op);
    assign w_add_alu   = ALU_OP_W'(OP_ADD);
    assign w_unused_ir = ^ir[14:0];
    assign w_in_wait   = (r_state == S_T2)
                       || ((r_state == S_E4) && (w_class == C_LD))
                       || ((r_state == S_E5) && (w_class == C_ST));

`ifdef DATAPATH_SEQUENCER_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_fault;

    assign w_timeout = w_in_wait && !mem_ready
                     && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign fault     = r_fault;

    // Wait counter restarts on every non-waiting cycle, so each wait state entry begins at zero.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_wait_cnt <= '0;
            r_fault    <= 1'b0;
        end else begin
            if (w_in_wait && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end else begin
                r_fault <= r_fault;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; memory waits hold until mem_ready or watchdog expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_T0;
                else       w_next = S_IDLE;
            end
            S_T0: w_next = S_T1;
            S_T1: w_next = S_T2;
            S_T2: begin
                if (mem_ready)      w_next = S_T3;
                else if (w_timeout) w_next = S_HALTED;
                else                w_next = S_T2;
            end
            S_T3: w_next = S_DEC;
            S_DEC: begin
                case (w_class)
                    C_LD, C_ST, C_ALU, C_IMM, C_MULDIV: w_next = S_E1;
                    C_HALT:                             w_next = S_HALTED;
                    default:                            w_next = S_T0;
                endcase
            end
            S_E1: w_next = S_E2;
            S_E2: w_next = S_E3;
            S_E3: begin
                if ((w_class == C_ALU) || (w_class == C_IMM)) w_next = S_T0;
                else                                          w_next = S_E4;
            end
            S_E4: begin
                case (w_class)
                    C_LD: begin
                        if (mem_ready)      w_next = S_E5;
                        else if (w_timeout) w_next = S_HALTED;
                        else                w_next = S_E4;
                    end
                    C_ST:    w_next = S_E5;
                    default: w_next = S_T0;
                endcase
            end
            S_E5: begin
                if (w_class == C_ST) begin
                    if (mem_ready)      w_next = S_T0;
                    else if (w_timeout) w_next = S_HALTED;
                    else                w_next = S_E5;
                end else begin
                    w_next = S_T0;
                end
            end
            S_HALTED: w_next = S_HALTED;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode; each state enables at most one bus driver.
    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0;
        LOin = 1'b0; Csignextendedout = 1'b0; Read = 1'b0; Write = 1'b0;
        Rin     = 16'h0000;
        Rout    = 16'h0000;
        alu_op  = w_add_alu;
        run     = 1'b1;
        illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                alu_op = '0;
                run    = 1'b0;
            end
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1;
            end
            S_T2: begin
                Read = 1'b1; MDRin = 1'b1;
            end
            S_T3: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_DEC: illegal = (w_class == C_ILL);
            S_E1: begin
                alu_op = w_op_alu;
                Yin    = 1'b1;
                if (w_class == C_MULDIV) Rout = w_ra_oh;
                else                     Rout = w_rb_oh;
            end
            S_E2: begin
                alu_op = w_op_alu;
                Zin    = 1'b1;
                case (w_class)
                    C_ALU:    Rout = w_rc_oh;
                    C_MULDIV: Rout = w_rb_oh;
                    C_IMM:    Csignextendedout = 1'b1;
                    C_LD, C_ST: begin
                        Csignextendedout = 1'b1;
                        alu_op           = w_add_alu;
                    end
                    default:  Zin = 1'b0;
                endcase
            end
            S_E3: begin
                alu_op = w_op_alu;
                case (w_class)
                    C_ALU, C_IMM: begin
                        Zlowout = 1'b1; Rin = w_ra_oh;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                    end
                    C_LD, C_ST: begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end
                    default: Zlowout = 1'b0;
                endcase
            end
            S_E4: begin
                alu_op = w_op_alu;
                case (w_class)
                    C_MULDIV: begin
                        Zhighout = 1'b1; HIin = 1'b1;
                    end
                    C_LD: begin
                        Read = 1'b1; MDRin = 1'b1;
                    end
                    // Read stays low so the MDR loads from the bus, not from memory.
                    C_ST: begin
                        Rout = w_ra_oh; MDRin = 1'b1;
                    end
                    default: MDRin = 1'b0;
                endcase
            end
            S_E5: begin
                alu_op = w_op_alu;
                case (w_class)
                    C_LD: begin
                        MDRout = 1'b1; Rin = w_ra_oh;
                    end
                    C_ST:    Write = 1'b1;
                    default: Write = 1'b0;
                endcase
            end
            S_HALTED: run = 1'b0;
            default: begin
                alu_op = '0;
                run    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer: exact per-cycle strobe patterns with hand-computed values.
module tb_datapath_sequencer;

    logic        clock = 1'b0;
    logic        clear, start, mem_ready;
    logic [31:0] ir;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin;
    logic Zlowout, Zhighout, HIin, LOin, Csignextendedout, Read, Write;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        run, illegal;
`ifdef DATAPATH_SEQUENCER_MEM_TIMEOUT_EN
    logic        fault;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [15:0] M_PCOUT = 16'h8000, M_PCIN = 16'h4000, M_INCPC = 16'h2000;
    localparam logic [15:0] M_MARIN = 16'h1000, M_MDRIN = 16'h0800, M_MDROUT = 16'h0400;
    localparam logic [15:0] M_IRIN = 16'h0200, M_YIN = 16'h0100, M_ZIN = 16'h0080;
    localparam logic [15:0] M_ZLO = 16'h0040, M_ZHI = 16'h0020, M_HIIN = 16'h0010;
    localparam logic [15:0] M_LOIN = 16'h0008, M_CSX = 16'h0004, M_READ = 16'h0002;
    localparam logic [15:0] M_WRITE = 16'h0001;

    logic [15:0] w_strb;
    assign w_strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin,
                     Zlowout, Zhighout, HIin, LOin, Csignextendedout, Read, Write};

    datapath_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Csignextendedout(Csignextendedout), .Read(Read), .Write(Write),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run), .illegal(illegal)
`ifdef DATAPATH_SEQUENCER_MEM_TIMEOUT_EN
        , .fault(fault)
`endif
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_cyc(input string tag, input logic [15:0] strb, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [4:0] op,
                              input logic rn, input logic ill);
        check_eq({tag, "/strb"}, {16'h0000, w_strb}, {16'h0000, strb});
        check_eq({tag, "/Rin"}, {16'h0000, Rin}, {16'h0000, rin});
        check_eq({tag, "/Rout"}, {16'h0000, Rout}, {16'h0000, rout});
        check_eq({tag, "/alu_op"}, {27'h0, alu_op}, {27'h0, op});
        check_eq({tag, "/run"}, {31'h0, run}, {31'h0, rn});
        check_eq({tag, "/illegal"}, {31'h0, illegal}, {31'h0, ill});
    endtask

    // Expects the sequencer in T0; walks T0..T3 with 'waits' cycles of mem_ready low in T2.
    task automatic do_fetch(input string tag, input int waits);
        expect_cyc({tag, ".T0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc({tag, ".T1"}, M_ZLO | M_PCIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            expect_cyc({tag, ".T2"}, M_READ | M_MDRIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
            if (i == waits) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        expect_cyc({tag, ".T3"}, M_MDROUT | M_IRIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;
        tick();
        tick();
        clear = 1'b0;
        expect_cyc("reset", 16'h0, 16'h0, 16'h0, 5'b00000, 1'b0, 1'b0);
        tick();
        expect_cyc("idle_hold", 16'h0, 16'h0, 16'h0, 5'b00000, 1'b0, 1'b0);

        // ADD R3,R1,R2: ra=3, rb=1, rc=2; fetch with mem_ready low for 3 cycles.
        ir = 32'h1989_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_fetch("add", 3);
        expect_cyc("add.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("add.E1", M_YIN, 16'h0, 16'h0002, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("add.E2", M_ZIN, 16'h0, 16'h0004, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("add.E3", M_ZLO, 16'h0008, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();

        // LD R5,0x10(R2); data arrives on the 2nd E4 cycle.
        ir = 32'h0290_0010;
        do_fetch("ld", 0);
        expect_cyc("ld.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("ld.E1", M_YIN, 16'h0, 16'h0004, 5'b00000, 1'b1, 1'b0);
        tick();
        expect_cyc("ld.E2", M_CSX | M_ZIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("ld.E3", M_ZLO | M_MARIN, 16'h0, 16'h0, 5'b00000, 1'b1, 1'b0);
        tick();
        expect_cyc("ld.E4a", M_READ | M_MDRIN, 16'h0, 16'h0, 5'b00000, 1'b1, 1'b0);
        tick();
        expect_cyc("ld.E4b", M_READ | M_MDRIN, 16'h0, 16'h0, 5'b00000, 1'b1, 1'b0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        expect_cyc("ld.E5", M_MDROUT, 16'h0020, 16'h0, 5'b00000, 1'b1, 1'b0);
        tick();

        // ST R5,0x10(R2); write completes after one wait cycle.
        ir = 32'h0A90_0010;
        do_fetch("st", 0);
        expect_cyc("st.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("st.E1", M_YIN, 16'h0, 16'h0004, 5'b00001, 1'b1, 1'b0);
        tick();
        expect_cyc("st.E2", M_CSX | M_ZIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("st.E3", M_ZLO | M_MARIN, 16'h0, 16'h0, 5'b00001, 1'b1, 1'b0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        expect_cyc("st.E4", M_MDRIN, 16'h0, 16'h0020, 5'b00001, 1'b1, 1'b0);
        tick();
        expect_cyc("st.E5a", M_WRITE, 16'h0, 16'h0, 5'b00001, 1'b1, 1'b0);
        tick();
        expect_cyc("st.E5b", M_WRITE, 16'h0, 16'h0, 5'b00001, 1'b1, 1'b0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // MUL R4,R6.
        ir = 32'h7230_0000;
        do_fetch("mul", 1);
        expect_cyc("mul.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("mul.E1", M_YIN, 16'h0, 16'h0010, 5'b01110, 1'b1, 1'b0);
        tick();
        expect_cyc("mul.E2", M_ZIN, 16'h0, 16'h0040, 5'b01110, 1'b1, 1'b0);
        tick();
        expect_cyc("mul.E3", M_ZLO | M_LOIN, 16'h0, 16'h0, 5'b01110, 1'b1, 1'b0);
        tick();
        expect_cyc("mul.E4", M_ZHI | M_HIIN, 16'h0, 16'h0, 5'b01110, 1'b1, 1'b0);
        tick();

        // ADDI R1,R2,imm.
        ir = 32'h5890_0005;
        do_fetch("addi", 0);
        expect_cyc("addi.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("addi.E1", M_YIN, 16'h0, 16'h0004, 5'b01011, 1'b1, 1'b0);
        tick();
        expect_cyc("addi.E2", M_CSX | M_ZIN, 16'h0, 16'h0, 5'b01011, 1'b1, 1'b0);
        tick();
        expect_cyc("addi.E3", M_ZLO, 16'h0002, 16'h0, 5'b01011, 1'b1, 1'b0);
        tick();

        // Illegal opcode 11111: one-cycle pulse in DEC, then T0.
        ir = 32'hF800_0000;
        do_fetch("ill", 0);
        expect_cyc("ill.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b1);
        tick();
        expect_cyc("ill.T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);

        // NOP goes straight back to T0.
        ir = 32'hD000_0000;
        do_fetch("nop", 0);
        expect_cyc("nop.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();

        // Reset during E2 of ADD.
        ir = 32'h1989_0000;
        do_fetch("rst", 0);
        tick();
        tick();
        expect_cyc("rst.E2", M_ZIN, 16'h0, 16'h0004, 5'b00011, 1'b1, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_cyc("rst.idle", 16'h0, 16'h0, 16'h0, 5'b00000, 1'b0, 1'b0);

        // HALT: stays halted and ignores start until clear.
        ir = 32'hD800_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        do_fetch("halt", 0);
        expect_cyc("halt.DEC", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        tick();
        expect_cyc("halt.H", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b0, 1'b0);
        start = 1'b1;
        mem_ready = 1'b1;
        tick();
        tick();
        start = 1'b0;
        mem_ready = 1'b0;
        expect_cyc("halt.start", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_cyc("halt.clear", 16'h0, 16'h0, 16'h0, 5'b00000, 1'b0, 1'b0);

`ifdef DATAPATH_SEQUENCER_MEM_TIMEOUT_EN
        // Memory never answers in T2: fault after 64 wait cycles.
        check_eq("to.fault0", {31'h0, fault}, 32'h0);
        ir = 32'h1989_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 63; i++) tick();
        expect_cyc("to.T2_63", M_READ | M_MDRIN, 16'h0, 16'h0, 5'b00011, 1'b1, 1'b0);
        check_eq("to.fault63", {31'h0, fault}, 32'h0);
        tick();
        check_eq("to.fault64", {31'h0, fault}, 32'h1);
        expect_cyc("to.halted", 16'h0, 16'h0, 16'h0, 5'b00011, 1'b0, 1'b0);
        tick();
        check_eq("to.sticky", {31'h0, fault}, 32'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("to.cleared", {31'h0, fault}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
